// File: rtl/aes_pkg.sv
// AES-128 constants, controller state type and byte-level helpers.
// Latency: pure combinational functions.
// Backpressure: not applicable.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_ctrl_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte-wise S-box substitution; independent of byte layout.
  function automatic logic [127:0] sub_bytes128(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Row-major ShiftRows: row r rotates left by r columns.
  function automatic logic [127:0] shift_rows128(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = s[127-8*(4*r+((c+r)%4)) -: 8];
    return o;
  endfunction

  // FIPS byte k <-> row-major (k%4, k/4); the mapping is its own inverse.
  function automatic logic [127:0] transpose128(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*(4*(k%4)+(k/4)) -: 8] = s[127-8*k -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// Next AES-128 round key from the current one (RotWord, SubWord, rcon).
// Latency: combinational.
// Backpressure: none, pure function of rk and rcon.
module aes128_key_step (
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);
  import aes_pkg::*;

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;
  assign t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns on a row-major 128-bit state.
// Latency: combinational.
// Backpressure: none, pure function of din.
module mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  // Each column c gathers byte c of each row, mixes, and scatters back.
  always_comb begin
    dout = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = din[127-8*c -: 8];
      a1 = din[95-8*c  -: 8];
      a2 = din[63-8*c  -: 8];
      a3 = din[31-8*c  -: 8];
      dout[127-8*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      dout[95-8*c  -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      dout[63-8*c  -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      dout[31-8*c  -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  end

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Latency: accept edge plus 10 round edges; out_valid from the 11th cycle after accept.
// Backpressure: out_valid/out_text held until out_ready; in_ready low while busy.
module aes128_enc_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_ctrl_state_t st, st_nxt;
  logic [127:0] state, rk, rk_next, sr, mc, round_out;
  logic [3:0]   rnd, rcon_idx;
  logic [7:0]   rcon;
  logic         load;

  // rcon[rnd] with rnd counted from 1; zero outside the valid round range.
  assign rcon_idx = rnd - 4'd1;
  assign rcon     = (rnd != 4'd0 && rcon_idx < 4'd10) ? RCON[rcon_idx] : 8'h00;

  aes128_key_step u_key_step (
    .rk      (rk),
    .rcon    (rcon),
    .rk_next (rk_next)
  );

  assign sr = shift_rows128(sub_bytes128(state));

  mix_columns u_mix (
    .din  (sr),
    .dout (mc)
  );

  // The final round skips MixColumns.
  assign round_out = ((rnd == LAST_RND) ? sr : mc) ^ transpose128(rk_next);
  assign out_text  = transpose128(state);

  // Next-state decode and load strobe.
  always_comb begin
    st_nxt = st;
    load   = 1'b0;
    case (st)
      IDLE: begin
        if (in_valid) begin
          load   = 1'b1;
          st_nxt = ROUND;
        end
      end
      ROUND:   if (rnd == LAST_RND) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // State register; handshake flags are flops so no out_ready->in_ready path exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      st        <= st_nxt;
      in_ready  <= (st_nxt == IDLE);
      out_valid <= (st_nxt == DONE);
      busy      <= (st_nxt != IDLE);
    end
  end

  // Datapath: load on accept, one round per ROUND cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      rk    <= '0;
      rnd   <= '0;
    end else if (load) begin
      state <= transpose128(in_text) ^ transpose128(in_key);
      rk    <= in_key;
      rnd   <= 4'd1;
    end else if (st == ROUND) begin
      state <= round_out;
      rk    <= rk_next;
      if (rnd != LAST_RND) rnd <= rnd + 4'd1;
    end
  end

endmodule
